// File: rtl/binary_add_pkg.sv
// binary_add_pkg: shared constants, per-stage control bundle and helpers
// for the pipelined binary adder (binary_add_pipe).
package binary_add_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_STAGES = 2;

  // Control bundle that travels alongside each beat through the pipeline.
  // carry holds the chunk carry for intermediate stages; in the last stage
  // it holds the final carry/borrow as presented on cout.
  typedef struct packed {
    logic valid;
    logic carry;
    logic sub;
    logic ovf;
  } stage_ctrl_t;

  // Ceiling log2 for elaboration-time sizing.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/binary_add_chunk.sv
// binary_add_chunk: purely combinational CW-bit ripple full adder.
// Besides the carry out it exposes the carry into the chunk MSB, which the
// last pipeline stage needs to derive signed overflow.
module binary_add_chunk
  import binary_add_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic [CW-1:0] a_i,
  input  logic [CW-1:0] b_i,
  input  logic          cin_i,
  output logic [CW-1:0] s_o,
  output logic          cout_o,
  output logic          cmsb_o
);

  logic [CW:0] carry;

  // Ripple the carry bit by bit from the chunk carry-in upward.
  always_comb begin
    carry    = '0;
    carry[0] = cin_i;
    for (int i = 0; i < CW; i++) begin
      carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign s_o    = a_i ^ b_i ^ carry[CW-1:0];
  assign cout_o = carry[CW];
  assign cmsb_o = carry[CW-1];

endmodule

// File: rtl/binary_add_pipe.sv
// binary_add_pipe: WIDTH-bit add/subtract split into STAGES registered
// ripple chunks, with valid/ready handshake and global stall.
// Optional feature macro: BINARY_ADD_SAT_EN enables signed saturation of
// the result in the last stage when overflow occurs.
module binary_add_pipe
  import binary_add_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = WIDTH / STAGES;

  logic stall;
  logic advance;
  logic accept;

  assign stall    = out_valid & ~out_ready;
  assign advance  = ~stall;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] aIn;
    logic [WIDTH-1:0] bIn;
    logic [WIDTH-1:0] sumIn;
    stage_ctrl_t      ctrlIn;

    logic [CW-1:0]    chunkS;
    logic             chunkCout;
    logic             chunkCmsb;

    logic [WIDTH-1:0] sum_d;
    logic             carry_d;
    logic             ovf_d;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    stage_ctrl_t      ctrl_q;

    if (k == 0) begin : g_src
      // Stage 0 takes operands straight from the ports; subtraction becomes
      // A + ~B + ~cin.
      assign aIn    = a;
      assign bIn    = sub ? ~b : b;
      assign sumIn  = '0;
      assign ctrlIn = '{valid: accept, carry: cin ^ sub, sub: sub, ovf: 1'b0};
    end else begin : g_src
      assign aIn    = g_stage[k-1].a_q;
      assign bIn    = g_stage[k-1].b_q;
      assign sumIn  = g_stage[k-1].sum_q;
      assign ctrlIn = g_stage[k-1].ctrl_q;
    end

    binary_add_chunk #(
      .CW(CW)
    ) u_chunk (
      .a_i   (aIn[k*CW +: CW]),
      .b_i   (bIn[k*CW +: CW]),
      .cin_i (ctrlIn.carry),
      .s_o   (chunkS),
      .cout_o(chunkCout),
      .cmsb_o(chunkCmsb)
    );

    // Merge this chunk into the partial sum; the last stage also forms the
    // borrow, overflow and (optionally) the saturated result.
    always_comb begin
      sum_d              = sumIn;
      sum_d[k*CW +: CW]  = chunkS;
      ovf_d              = chunkCmsb ^ chunkCout;
      carry_d            = chunkCout;
      if (k == STAGES - 1) begin
        carry_d = chunkCout ^ ctrlIn.sub;
`ifdef BINARY_ADD_SAT_EN
        if (ovf_d) begin
          sum_d = aIn[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                               : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
      end
    end

    // Stage register: valid advances every unstalled cycle so bubbles flow;
    // data only loads for real beats so the output holds its last value.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_q    <= '0;
        b_q    <= '0;
        sum_q  <= '0;
        ctrl_q <= '0;
      end else if (advance) begin
        ctrl_q.valid <= ctrlIn.valid;
        if (ctrlIn.valid) begin
          a_q          <= aIn;
          b_q          <= bIn;
          sum_q        <= sum_d;
          ctrl_q.carry <= carry_d;
          ctrl_q.sub   <= ctrlIn.sub;
          ctrl_q.ovf   <= ovf_d;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].ctrl_q.valid;
  assign sum       = g_stage[STAGES-1].sum_q;
  assign cout      = g_stage[STAGES-1].ctrl_q.carry;
  assign ovf       = g_stage[STAGES-1].ctrl_q.ovf;

endmodule

// File: tb/tb_binary_add_pipe.sv
// tb_binary_add_pipe: self-checking bench for binary_add_pipe (16 bits,
// 2 stages). Honours BINARY_ADD_SAT_EN when computing expected results.
module tb_binary_add_pipe;

  localparam int W      = 16;
  localparam int STAGES = 2;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int   checks = 0;
  int   fails  = 0;
  exp_t expQ[$];

  binary_add_pipe #(
    .WIDTH (W),
    .STAGES(STAGES)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] ua, input logic [W-1:0] ub,
                                 input logic c, input logic s);
    exp_t   e;
    longint x, y, r, sx, sy, sr;
    x  = longint'(ua);
    y  = longint'(ub);
    sx = longint'($signed(ua));
    sy = longint'($signed(ub));
    if (!s) begin
      r   = x + y + longint'(c);
      sr  = sx + sy + longint'(c);
      e.c = (r >= (64'sd1 <<< W));
    end else begin
      r   = x - y - longint'(c);
      sr  = sx - sy - longint'(c);
      e.c = (x < y + longint'(c));
    end
    e.s = r[W-1:0];
    e.o = (sr > (64'sd1 <<< (W-1)) - 1) || (sr < -(64'sd1 <<< (W-1)));
`ifdef BINARY_ADD_SAT_EN
    if (e.o) e.s = ua[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    return e;
  endfunction

  // Compare process: record accepted beats, check each retired result in order.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      expQ.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL stream extra result: got sum 0x%0h, expected no result", sum);
        end else begin
          e = expQ.pop_front();
          check("stream sum", sum, e.s);
          check("stream cout", cout, e.c);
          check("stream ovf", ovf, e.o);
        end
      end
      check("in_ready", in_ready, !(out_valid && !out_ready));
      if (in_valid && in_ready) expQ.push_back(model(a, b, cin, sub));
    end
  end

  // Present one beat and hold it until the DUT accepts it.
  task automatic applyStimulus(input logic [W-1:0] va, input logic [W-1:0] vb,
                               input logic vc, input logic vs);
    int n;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a = va; b = vb; cin = vc; sub = vs;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("accept timeout", 32'(n), 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait for the result of the last beat and compare to literal values.
  task automatic checkOutput(input string name, input logic [W-1:0] es,
                             input logic ec, input logic eo);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({name, " latency"}, 32'(n + 1), STAGES);
    check({name, " sum"}, sum, es);
    check({name, " cout"}, cout, ec);
    check({name, " ovf"}, ovf, eo);
  endtask

  // Global watchdog so the run always ends.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] got[8];
    int           gotN;
    int           idx;
    int           sent;
    int           cyc;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", out_valid, 0);
    check("reset sum", sum, 0);
    check("reset cout", cout, 0);
    check("reset ovf", ovf, 0);
    check("reset in_ready", in_ready, 1);
    rst_n = 1'b1;

    $display("[TB] directed arithmetic");
    applyStimulus(16'h00FF, 16'h0001, 1'b0, 1'b0);
    checkOutput("add chunk carry", 16'h0100, 1'b0, 1'b0);
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    checkOutput("add wrap", 16'h0000, 1'b1, 1'b0);
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0);
`ifdef BINARY_ADD_SAT_EN
    checkOutput("add overflow", 16'h7FFF, 1'b0, 1'b1);
`else
    checkOutput("add overflow", 16'h8000, 1'b0, 1'b1);
`endif
    applyStimulus(16'h0003, 16'h0005, 1'b0, 1'b1);
    checkOutput("sub borrow", 16'hFFFE, 1'b1, 1'b0);
    applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b1);
`ifdef BINARY_ADD_SAT_EN
    checkOutput("sub overflow", 16'h8000, 1'b0, 1'b1);
`else
    checkOutput("sub overflow", 16'h7FFF, 1'b0, 1'b1);
`endif
    applyStimulus(16'h1234, 16'h4321, 1'b1, 1'b0);
    checkOutput("add cin", 16'h5556, 1'b0, 1'b0);
    applyStimulus(16'h0005, 16'h0005, 1'b1, 1'b1);
    checkOutput("sub borrow-in", 16'hFFFF, 1'b1, 1'b0);

    $display("[TB] backpressure");
    gotN = 0;
    idx  = 0;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      #1;
      out_ready = !(c >= 3 && c <= 5);
      if (idx < 4) begin
        in_valid = 1'b1;
        a = 16'(idx + 1); b = 16'(idx + 1); cin = 1'b0; sub = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (c >= 3 && c <= 5) begin
        check("bp in_ready", in_ready, 0);
        check("bp out_valid", out_valid, 1);
        check("bp held sum", sum, 16'h0002);
      end
      if (out_valid && out_ready && gotN < 8) begin
        got[gotN] = sum;
        gotN++;
      end
      if (in_valid && in_ready) idx++;
      @(posedge clk);
    end
    check("bp result count", 32'(gotN), 4);
    for (int i = 0; i < 4; i++) check("bp result order", got[i], 32'(2 * (i + 1)));

    $display("[TB] reset with beats in flight");
    #1;
    out_ready = 1'b1;
    in_valid = 1'b1; a = 16'd10; b = 16'd20; cin = 1'b0; sub = 1'b0;
    @(posedge clk);
    #1;
    a = 16'd30; b = 16'd40;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("flush out_valid", out_valid, 0);
    check("flush sum", sum, 0);
    check("flush cout", cout, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post-reset idle", out_valid, 0);
    end
    applyStimulus(16'h0101, 16'h0202, 1'b0, 1'b0);
    checkOutput("post-reset beat", 16'h0303, 1'b0, 1'b0);

    $display("[TB] random stream");
    sent = 0;
    cyc  = 0;
    while (sent < 10000 && cyc < 60000) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = 16'($urandom);
      b         = 16'($urandom);
      cin       = 1'($urandom_range(0, 1));
      sub       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    check("random beats sent", 32'(sent), 10000);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (STAGES + 3) @(posedge clk);
    #1;
    check("drain empty", 32'(expQ.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
